// File: rtl/dpmem_rr_arbiter.sv
// Round-robin arbiter that multiplexes NREQ requesters onto one synchronous memory port
// and routes each read's return data back to the requester that issued it.
module dpmem_rr_arbiter #(
    parameter int DEPTH  = 10,
    parameter int WIDTH  = 32,
    parameter int NREQ   = 4,
    parameter int OUTREG = 1
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*DEPTH-1:0]  req_addr,
    input  logic [NREQ*WIDTH-1:0]  req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [DEPTH-1:0]       mem_addr,
    output logic [WIDTH-1:0]       mem_di,
    input  logic [WIDTH-1:0]       mem_do
);

    localparam int              LAT    = 1 + OUTREG;
    localparam int              IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDW:0]    NREQ_W = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0]  LAST   = IDW'(NREQ - 1);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           gnt_found;
    logic [IDW-1:0] gnt_id;
    logic [IDW:0]   cand;
    logic           rd_acc;

    logic [LAT-1:0] vld_q, vld_d;
    logic [IDW-1:0] id_q [LAT];

    // Search starts at the pointer and wraps; the extra bit in cand absorbs ptr+j before the wrap.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int j = 0; j < NREQ; j++) begin
            cand = {1'b0, ptr_q} + (IDW + 1)'(j);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[IDW-1:0];
            end
        end
        if (srst) begin
            gnt_found = 1'b0;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_found) begin
            ptr_d = (gnt_id == LAST) ? '0 : gnt_id + IDW'(1);
        end
    end

    assign req_ready = gnt_found ? (NREQ'(1) << gnt_id) : '0;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_di   = '0;
        if (gnt_found) begin
            mem_we   = req_we[gnt_id];
            mem_addr = req_addr[int'(gnt_id) * DEPTH +: DEPTH];
            mem_di   = req_wdata[int'(gnt_id) * WIDTH +: WIDTH];
        end
    end

    // The memory output pipeline only advances while enabled, so enable is tied high outside reset.
    assign mem_en = ~srst;
    assign rd_acc = gnt_found & ~req_we[gnt_id];

    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_acc;
        for (int s = 1; s < LAT; s++) begin
            vld_d[s] = vld_q[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            ptr_q <= '0;
            vld_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
        end
    end

    // Requester ids need no reset: they are only observed alongside a set valid bit.
    always_ff @(posedge clk) begin
        id_q[0] <= gnt_id;
        for (int s = 1; s < LAT; s++) begin
            id_q[s] <= id_q[s-1];
        end
    end

    assign rsp_valid = (vld_q[LAT-1] && !srst) ? (NREQ'(1) << id_q[LAT-1]) : '0;
    assign rsp_data  = mem_do;

endmodule

// File: doc/dpmem_rr_arbiter.md
DPMEM_RR_ARBITER -- requirements
Module: dpmem_rr_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 10, giving the memory address width in bits.
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the data width in bits.
REQ-003 The block SHALL have parameter NREQ, default 4, giving the number of requesters; legal range is 2..8.
REQ-004 The block SHALL have parameter OUTREG, default 1, matching the output-register setting of the memory port it drives; legal values are 0 and 1.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  sole clock; all state updates on its rising edge.
- srst  in  1  synchronous reset, active-high.
REQ-006 The block SHALL have the following requester-side ports:
- req_valid  in  NREQ  bit i: requester i presents an access.
- req_ready  out  NREQ  bit i: requester i is granted this cycle (one-hot or zero).
- req_we  in  NREQ  bit i: 1 means write, 0 means read.
- req_addr  in  NREQ*DEPTH  slice i is the address of requester i.
- req_wdata  in  NREQ*WIDTH  slice i is the write data of requester i.
- rsp_valid  out  NREQ  bit i: read data for requester i is on rsp_data this cycle.
- rsp_data  out  WIDTH  shared read-return data.
REQ-007 The block SHALL have the following memory-side ports:
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory port write enable.
- mem_addr  out  DEPTH  memory port address.
- mem_di  out  WIDTH  memory port write data.
- mem_do  in  WIDTH  memory port read data.

Function
REQ-008 The block SHALL hold mem_en at 1 in every cycle where srst=0, because the memory output pipeline advances only when enabled.
REQ-009 The block SHALL assert at most one req_ready bit per cycle, and only for a requester with req_valid=1.
REQ-010 An access by requester i SHALL be accepted in the cycle where req_valid[i] and req_ready[i] are both 1.
REQ-011 req_ready SHALL be combinational from req_valid and the priority pointer, with no dependency on req_ready.
REQ-012 Arbitration SHALL be round-robin:
- search starts at pointer P and wraps from NREQ-1 to 0;
- the first valid requester wins;
- after a grant to requester k, P becomes (k+1) mod NREQ;
- with no grant, P is unchanged.
REQ-013 The memory-side outputs SHALL be driven combinationally from the granted requester:
- mem_addr and mem_di carry that requester's slices;
- mem_we = req_we of that requester;
- with no grant, mem_we=0 and mem_addr/mem_di=0.
REQ-014 Read latency SHALL be LAT = 1+OUTREG cycles: for a read accepted in cycle T, rsp_valid[id] SHALL be 1 in cycle T+LAT only, with rsp_data = mem_do.
REQ-015 The block SHALL track in-flight reads with a LAT-stage shift register of (valid, requester id), with id width clog2(NREQ); it SHALL have no response backpressure.
REQ-016 Writes SHALL produce no rsp_valid pulse.
REQ-017 Back-to-back reads SHALL each return in order, one per cycle, with a throughput of one access per cycle.
REQ-018 A read in cycle T+1 to an address written in cycle T SHALL return the new data.
REQ-019 A single requester with req_valid held at 1 and no competition SHALL be granted every cycle.
REQ-020 With all requesters continuously valid, each SHALL be granted exactly once per NREQ cycles, which bounds the wait to at most NREQ-1 cycles.
REQ-021 rsp_data SHALL equal mem_do in every cycle; only rsp_valid qualifies it.

Reset
REQ-022 While srst=1 the block SHALL drive req_ready=0, mem_en=0, mem_we=0 and rsp_valid=0.
REQ-023 srst=1 SHALL reset P to 0 and clear all shift-register stages, so that reads in flight at reset never produce rsp_valid, including when srst is asserted mid-operation.
REQ-024 In the first cycle after srst deasserts, the block SHALL accept requests, with requester 0 highest priority.

Verification
REQ-025 Single-requester write/read (NREQ=4, OUTREG=1): requester 2 writes 0xA5A5A5A5 to address 0x010, then reads 0x010 -> rsp_valid=4'b0100 exactly 2 cycles after the read accept, rsp_data=0xA5A5A5A5; no rsp_valid pulse for the write.
REQ-026 Round-robin fairness: all 4 requesters valid for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3 and req_ready always one-hot.
REQ-027 Pointer skip: only requesters 1 and 3 valid, P=0 -> grants alternate 1,3,1,3; mem_we=0 in cycles without a grant.
REQ-028 Write-then-read: write 0x1234 to address 5 in cycle T, read address 5 in cycle T+1 -> 0x1234 returned at T+1+LAT; repeat with OUTREG=0 -> returned at T+2.
REQ-029 Reset mid-flight: read accepted in cycle T, srst=1 in cycle T+1 -> no rsp_valid in cycles T+1..T+3; first post-reset grant goes to requester 0 when all requesters are valid.
REQ-030 Streaming: requester 0 issues reads to addresses 0..15 back-to-back -> 16 consecutive rsp_valid=1 cycles with data in address order.
